// File: rtl/mem_pkg.sv
// Shared memory-map constants and the sprite-DMA state type.
package mem_pkg;

   localparam logic [15:0] ADDR_SPR_RAM_DMA = 16'h4014;
   localparam logic [15:0] ADDR_OAM_DATA    = 16'h2004;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HALT  = 3'd1,
      ALIGN = 3'd2,
      READ  = 3'd3,
      WRITE = 3'd4
   } dma_state_t;

endpackage

// File: rtl/spr_dma.sv
// Sprite DMA: halts the CPU and copies one 256-byte page to the OAM data port.
// Optional macro SPR_DMA_ALIGN_EN adds an alignment cycle on odd-parity starts.
module spr_dma
   import mem_pkg::*;
#(
   parameter logic [15:0] DMA_TRIG_ADDR = ADDR_SPR_RAM_DMA,
   parameter logic [15:0] OAM_DATA_ADDR = ADDR_OAM_DATA
) (
   input  logic        clk,
   input  logic        b_rst,
   input  logic [15:0] cpu_addr_out,
   input  logic [7:0]  cpu_data_out,
   input  logic        cpu_wen,
   output logic        cpu_rdy,
   output logic [15:0] dma_addr,
   output logic        dma_ren,
   output logic        dma_wen,
   input  logic [7:0]  dma_rdata,
   output logic [7:0]  dma_wdata,
   output logic        dma_busy,
   output logic        dma_done
);

   dma_state_t r_state;
   dma_state_t w_next;
   logic [7:0] r_page;
   logic [7:0] r_index;
   logic [7:0] r_latch;
   logic       r_done;
   logic       w_trig;

   assign w_trig = cpu_wen && (cpu_addr_out == DMA_TRIG_ADDR);

`ifdef SPR_DMA_ALIGN_EN
   logic r_parity;

   always_ff @(posedge clk or negedge b_rst) begin
      if (!b_rst) r_parity <= 1'b0;
      else        r_parity <= ~r_parity;
   end
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:  if (w_trig) w_next = HALT;
`ifdef SPR_DMA_ALIGN_EN
         HALT:  w_next = r_parity ? ALIGN : READ;
`else
         HALT:  w_next = READ;
`endif
         ALIGN: w_next = READ;
         READ:  w_next = WRITE;
         WRITE: w_next = (r_index == 8'hFF) ? IDLE : READ;
         default: w_next = IDLE;
      endcase
   end

   // Triggers while busy never reach the page latch because only IDLE samples them.
   always_ff @(posedge clk or negedge b_rst) begin
      if (!b_rst) begin
         r_state <= IDLE;
         r_page  <= 8'h00;
         r_index <= 8'h00;
         r_latch <= 8'h00;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_done  <= (r_state == WRITE) && (r_index == 8'hFF);
         if ((r_state == IDLE) && w_trig) begin
            r_page  <= cpu_data_out;
            r_index <= 8'h00;
         end
         if (r_state == READ)  r_latch <= dma_rdata;
         if (r_state == WRITE) r_index <= r_index + 8'd1;
      end
   end

   always_comb begin
      cpu_rdy   = (r_state == IDLE);
      dma_busy  = (r_state != IDLE);
      dma_ren   = (r_state == READ);
      dma_wen   = (r_state == WRITE);
      dma_done  = r_done;
      dma_addr  = 16'h0000;
      dma_wdata = 8'h00;
      if (r_state == READ) begin
         dma_addr = {r_page, r_index};
      end else if (r_state == WRITE) begin
         dma_addr  = OAM_DATA_ADDR;
         dma_wdata = r_latch;
      end
   end

endmodule

// File: tb/tb_spr_dma.sv
// Self-checking bench for spr_dma: transfer-level model plus directed scenarios.
module tb_spr_dma;

`ifdef SPR_DMA_ALIGN_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        b_rst;
   logic [15:0] cpu_addr_out;
   logic [7:0]  cpu_data_out;
   logic        cpu_wen;
   logic        cpu_rdy;
   logic [15:0] dma_addr;
   logic        dma_ren;
   logic        dma_wen;
   logic [7:0]  dma_rdata;
   logic [7:0]  dma_wdata;
   logic        dma_busy;
   logic        dma_done;

   logic [7:0]  mem [0:65535];

   assign dma_rdata = mem[dma_addr];

   always #5 clk = ~clk;

   spr_dma dut (
      .clk          (clk),
      .b_rst        (b_rst),
      .cpu_addr_out (cpu_addr_out),
      .cpu_data_out (cpu_data_out),
      .cpu_wen      (cpu_wen),
      .cpu_rdy      (cpu_rdy),
      .dma_addr     (dma_addr),
      .dma_ren      (dma_ren),
      .dma_wen      (dma_wen),
      .dma_rdata    (dma_rdata),
      .dma_wdata    (dma_wdata),
      .dma_busy     (dma_busy),
      .dma_done     (dma_done)
   );

   // Transfer model: mT counts cycles since the first non-IDLE cycle, mHdr is 1 or 2 lead cycles.
   logic       mParity;
   logic       mBusy;
   logic       mDone;
   logic [7:0] mPage;
   int         mT;
   int         mHdr;

   always @(posedge clk or negedge b_rst) begin
      if (!b_rst) begin
         mParity <= 1'b0;
         mBusy   <= 1'b0;
         mDone   <= 1'b0;
         mPage   <= 8'h00;
         mT      <= 0;
         mHdr    <= 1;
      end else begin
         mParity <= ~mParity;
         mDone   <= 1'b0;
         if (!mBusy) begin
            if (cpu_wen && cpu_addr_out == 16'h4014) begin
               mBusy <= 1'b1;
               mT    <= 0;
               mPage <= cpu_data_out;
            end
         end else begin
            if (mT == 0) mHdr <= (ALIGN_EN && mParity) ? 2 : 1;
            mT <= mT + 1;
            if (mT != 0 && mT == mHdr + 511) begin
               mBusy <= 1'b0;
               mDone <= 1'b1;
            end
         end
      end
   end

   int          tests = 0;
   int          fails = 0;
   int          printed = 0;
   bit          cmpEn = 1'b0;
   int          lowCycles, doneCount, wenCount, outside;
   logic [7:0]  firstWdata, lastWdata, tbPage;
   logic [15:0] lastRead;

   logic        eRen, eWen;
   logic [15:0] eAddr;
   logic [7:0]  eWdata;
   int          off;
   logic [7:0]  k;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic resetStats();
      lowCycles  = 0;
      doneCount  = 0;
      wenCount   = 0;
      outside    = 0;
      firstWdata = 8'h00;
      lastWdata  = 8'h00;
      lastRead   = 16'h0000;
   endtask

   task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] data);
      cpu_addr_out = addr;
      cpu_data_out = data;
      cpu_wen      = 1'b1;
      @(negedge clk);
      cpu_wen      = 1'b0;
      cpu_addr_out = 16'h0000;
      cpu_data_out = 8'h00;
   endtask

   // p is the parity wanted in the HALT cycle, which follows the trigger cycle.
   task automatic triggerWithParity(input logic [7:0] page, input logic p);
      @(negedge clk);
      while (mParity == p) @(negedge clk);
      applyStimulus(16'h4014, page);
   endtask

   task automatic waitDone(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 700; i++) begin
         @(negedge clk);
         if (dma_done) begin
            seen = 1'b1;
            break;
         end
      end
      #1;
      tests++;
      if (!seen) begin
         fails++;
         $display("[TB] FAIL %s timeout: dma_done not seen within 700 cycles", name);
      end
   endtask

   task automatic waitWrites(input int n);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 700; i++) begin
         @(negedge clk);
         #1;
         if (wenCount >= n) begin
            seen = 1'b1;
            break;
         end
      end
      tests++;
      if (!seen) begin
         fails++;
         $display("[TB] FAIL waitWrites timeout: got %0d writes, expected %0d", wenCount, n);
      end
   endtask

   initial begin
      b_rst        = 1'b0;
      cpu_addr_out = 16'h0000;
      cpu_data_out = 8'h00;
      cpu_wen      = 1'b0;
      tbPage       = 8'h02;
      for (int i = 0; i < 65536; i++) mem[i] = 8'hA5;
      for (int i = 0; i < 256; i++) begin
         mem[16'h0200 + i] = i[7:0];
         mem[16'hFF00 + i] = i[7:0] ^ 8'h5A;
      end
      resetStats();

      fork
         forever begin
            @(negedge clk);
            if (cmpEn) begin
               eRen = 1'b0; eWen = 1'b0; eAddr = 16'h0000; eWdata = 8'h00;
               if (mBusy && mT > 0 && !(mHdr == 2 && mT == 1)) begin
                  off = mT - mHdr;
                  k   = 8'(off / 2);
                  if (off % 2 == 0) begin
                     eRen  = 1'b1;
                     eAddr = {mPage, k};
                  end else begin
                     eWen   = 1'b1;
                     eAddr  = 16'h2004;
                     eWdata = mem[{mPage, k}];
                  end
               end
               tests++;
               if (dma_ren !== eRen || dma_wen !== eWen || dma_addr !== eAddr ||
                   dma_wdata !== eWdata || cpu_rdy !== !mBusy || dma_busy !== mBusy ||
                   dma_done !== mDone) begin
                  fails++;
                  if (printed < 20)
                     $display("[TB] FAIL cycle %0t: ren %b/%b wen %b/%b addr %h/%h wdata %h/%h rdy %b/%b busy %b/%b done %b/%b (got/expected)",
                              $time, dma_ren, eRen, dma_wen, eWen, dma_addr, eAddr, dma_wdata, eWdata,
                              cpu_rdy, !mBusy, dma_busy, mBusy, dma_done, mDone);
                  printed++;
               end
               if (!cpu_rdy) lowCycles++;
               if (dma_done) doneCount++;
               if (dma_wen) begin
                  wenCount++;
                  if (wenCount == 1) firstWdata = dma_wdata;
                  lastWdata = dma_wdata;
               end
               if (dma_ren) begin
                  lastRead = dma_addr;
                  if (dma_addr[15:8] != tbPage) outside++;
               end
            end
         end
      join_none

      #1;
      checkOutput("reset cpu_rdy", 32'(cpu_rdy), 32'd1);
      checkOutput("reset dma_busy", 32'(dma_busy), 32'd0);
      checkOutput("reset dma_addr", 32'(dma_addr), 32'h0);
      repeat (2) @(negedge clk);
      b_rst = 1'b1;
      cmpEn = 1'b1;

      // Even start from page 2.
      repeat (3) @(negedge clk);
      resetStats();
      triggerWithParity(8'h02, 1'b0);
      waitDone("even");
      checkOutput("even low cycles", 32'(lowCycles), 32'd513);
      checkOutput("even writes", 32'(wenCount), 32'd256);
      checkOutput("even first data", 32'(firstWdata), 32'h00);
      checkOutput("even last data", 32'(lastWdata), 32'hFF);
      checkOutput("even done pulses", 32'(doneCount), 32'd1);

      // Retrigger in the dma_done cycle, then an ignored retrigger at byte 100.
      resetStats();
      applyStimulus(16'h4014, 8'h02);
      checkOutput("retrigger busy", 32'(dma_busy), 32'd1);
      waitWrites(100);
      applyStimulus(16'h4014, 8'h07);
      waitDone("ignore");
      checkOutput("ignore outside page", 32'(outside), 32'd0);
      checkOutput("ignore writes", 32'(wenCount), 32'd256);
      checkOutput("ignore done pulses", 32'(doneCount), 32'd1);

      // Odd start.
      repeat (4) @(negedge clk);
      resetStats();
      triggerWithParity(8'h02, 1'b1);
      waitDone("odd");
      checkOutput("odd low cycles", 32'(lowCycles), ALIGN_EN ? 32'd514 : 32'd513);
      checkOutput("odd writes", 32'(wenCount), 32'd256);

      // Reset asserted at byte 37.
      repeat (3) @(negedge clk);
      resetStats();
      applyStimulus(16'h4014, 8'h02);
      waitWrites(37);
      b_rst = 1'b0;
      #1;
      checkOutput("rst cpu_rdy", 32'(cpu_rdy), 32'd1);
      checkOutput("rst dma_busy", 32'(dma_busy), 32'd0);
      checkOutput("rst dma_ren", 32'(dma_ren), 32'd0);
      checkOutput("rst dma_wen", 32'(dma_wen), 32'd0);
      checkOutput("rst dma_addr", 32'(dma_addr), 32'h0);
      checkOutput("rst dma_wdata", 32'(dma_wdata), 32'h0);
      checkOutput("rst dma_done", 32'(dma_done), 32'd0);
      @(negedge clk);
      #1;
      b_rst = 1'b1;
      repeat (40) @(negedge clk);
      #1;
      checkOutput("rst no more writes", 32'(wenCount), 32'd37);
      checkOutput("rst cpu_rdy after", 32'(cpu_rdy), 32'd1);

      // Page FF must not wrap into page 0.
      tbPage = 8'hFF;
      resetStats();
      applyStimulus(16'h4014, 8'hFF);
      waitDone("pageFF");
      checkOutput("pageFF last read", 32'(lastRead), 32'hFFFF);
      checkOutput("pageFF outside", 32'(outside), 32'd0);
      checkOutput("pageFF last data", 32'(lastWdata), 32'hA5);
      @(negedge clk);
      #1;
      checkOutput("pageFF idle", 32'(dma_busy), 32'd0);

      // Near-miss addresses must not trigger.
      resetStats();
      @(negedge clk);
      applyStimulus(16'h4015, 8'h02);
      applyStimulus(16'h2014, 8'h02);
      repeat (5) @(negedge clk);
      #1;
      checkOutput("badaddr low cycles", 32'(lowCycles), 32'd0);
      checkOutput("badaddr cpu_rdy", 32'(cpu_rdy), 32'd1);

      cmpEn = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/spr_dma.md
SPR_DMA -- requirements
Module: spr_dma

Interface
REQ-001 SHALL have parameter DMA_TRIG_ADDR, 16'h4014, CPU write address that starts a transfer.
REQ-002 SHALL have parameter OAM_DATA_ADDR, 16'h2004, destination address written once per byte.
REQ-003 SHALL have port clk  in  1  single clock for all state.
REQ-004 SHALL have port b_rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cpu_addr_out  in  16  CPU bus address.
REQ-006 SHALL have port cpu_data_out  in  8  CPU write data.
REQ-007 SHALL have port cpu_wen  in  1  CPU write strobe.
REQ-008 SHALL have port cpu_rdy  out  1  high = CPU may run; low = CPU halted.
REQ-009 SHALL have port dma_addr  out  16  address driven to memory while busy.
REQ-010 SHALL have port dma_ren  out  1  memory read strobe.
REQ-011 SHALL have port dma_wen  out  1  memory write strobe.
REQ-012 SHALL have port dma_rdata  in  8  memory read data, combinational, valid in the same cycle as dma_ren.
REQ-013 SHALL have port dma_wdata  out  8  memory write data.
REQ-014 SHALL have port dma_busy  out  1  high while a transfer is in progress.
REQ-015 SHALL have port dma_done  out  1  one-cycle pulse after the last write.

Function
REQ-016 SHALL run FSM states IDLE, HALT, ALIGN, READ, WRITE.
REQ-017 SHALL, in IDLE, trigger on a cycle with cpu_wen=1 and cpu_addr_out==DMA_TRIG_ADDR: latch page=cpu_data_out, clear the 8-bit index, enter HALT next cycle.
REQ-018 SHALL drive cpu_rdy=0 and dma_busy=1 in every state except IDLE; cpu_rdy falls the cycle after the trigger.
REQ-019 SHALL spend exactly one cycle in HALT with no memory strobes, then enter ALIGN when the parity flop is odd, else READ.
REQ-020 SHALL spend exactly one cycle in ALIGN with no strobes, then enter READ.
REQ-021 SHALL, in READ: drive dma_ren=1 and dma_addr={page,index}; capture dma_rdata into the byte latch at the clock edge; go to WRITE.
REQ-022 SHALL, in WRITE: drive dma_wen=1, dma_addr=OAM_DATA_ADDR and dma_wdata=latch; increment the index with 8-bit wrap; go to READ when the index was not 8'hFF, else go to IDLE and pulse dma_done.
REQ-023 SHALL complete in 513 cycles (even start) or 514 cycles (odd start) from the first non-IDLE cycle through the last WRITE, moving exactly 256 bytes.
REQ-024 SHALL toggle the parity flop every clock from reset, independent of the FSM.
REQ-025 SHALL ignore trigger writes while busy; the page latch stays unchanged.
REQ-026 SHALL hold dma_ren and dma_wen mutually exclusive, and drive dma_addr=0 and dma_wdata=0 whenever both strobes are low.
REQ-027 SHALL, for page 8'hFF, read 16'hFF00..16'hFFFF with no address wrap into page 0.
REQ-028 SHALL accept a trigger in the same cycle dma_done is high, because the FSM is already IDLE in that cycle.

Reset
REQ-029 SHALL, on b_rst=0, immediately and asynchronously force: state=IDLE, cpu_rdy=1, dma_busy=0, dma_done=0, dma_ren=0, dma_wen=0, dma_addr=0, dma_wdata=0, page=0, index=0, latch=0, parity=0.
REQ-030 SHALL abandon a transfer when reset asserts mid-transfer; it does not resume after deassertion.

Configuration
REQ-031 SHALL honour macro SPR_DMA_ALIGN_EN: when defined, ALIGN is used per REQ-019; when undefined, ALIGN is never entered, the parity flop is omitted, and every transfer takes 513 cycles.

Structure
REQ-032 SHALL take DMA_TRIG_ADDR/OAM_DATA_ADDR defaults and the FSM state enum typedef from mem_pkg; the trigger default equals ADDR_SPR_RAM_DMA.
REQ-033 SHALL be a single module with no sub-module; the index counter and byte latch are inline.

Verification
REQ-034 SHALL cover: memory 16'h0200+i preloaded with i, write 8'h02 to 16'h4014 on an even cycle -> 256 writes to 16'h2004 with data 0..255 in order, cpu_rdy low for 513 cycles, one dma_done pulse.
REQ-035 SHALL cover: the same trigger on an odd cycle with SPR_DMA_ALIGN_EN defined -> cpu_rdy low for 514 cycles; with the macro undefined -> 513 cycles.
REQ-036 SHALL cover: a second write of 8'h07 to 16'h4014 at byte 100 -> ignored; all 256 reads stay within page 8'h02.
REQ-037 SHALL cover: b_rst pulsed low at byte 37 -> outputs at reset values within the same cycle, no further dma_wen, cpu_rdy=1.
REQ-038 SHALL cover: page 8'hFF -> last read at 16'hFFFF, index wraps to 0, FSM returns to IDLE.
REQ-039 SHALL cover: a write to 16'h4015 or 16'h2014 -> no transfer starts, cpu_rdy stays 1.
